// File: rtl/secuenciador_sumador16_pkg.sv
// Shared codes for the nibble-serial adder sequencer and its 4-bit stage.
// No logic, no latency.
// No flow control.
package secuenciador_sumador16_pkg;

    localparam logic [1:0] MODO_HOLD  = 2'b00;
    localparam logic [1:0] MODO_SUMA  = 2'b01;
    localparam logic [1:0] MODO_RESTA = 2'b10;
    localparam logic [1:0] MODO_CLR   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int NIBBLES_DEF = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/secuenciador_sumador16_sel_nibble.sv
// Selects 4-bit slice idx of a wide bus.
// Purely combinational.
// No flow control.
module secuenciador_sumador16_sel_nibble #(
    parameter int NIBBLES = 4,
    parameter int IW      = 2
) (
    input  logic [4*NIBBLES-1:0] bus_i,
    input  logic [IW-1:0]        idx_i,
    output logic [3:0]           nib_o
);

    always_comb begin
        nib_o = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_i == i[IW-1:0]) nib_o = bus_i[4*i +: 4];
        end
    end

endmodule

// File: rtl/sumador4.sv
// Registered 4-bit adder/subtractor slice with ripple carry/borrow in and out.
// Latency: one edge from ENB/MODO/A/B/RCI to Q/RCO.
// No backpressure; ENB=0 or MODO=00 holds the result.
import secuenciador_sumador16_pkg::*;

module sumador4 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enb_i,
    input  logic [1:0] modo_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       rci_i,
    output logic [3:0] q_o,
    output logic       rco_o
);

    logic [4:0] sum;
    logic [4:0] dif;
    logic [3:0] q_q;
    logic       rco_q;

    assign sum = {1'b0, a_i} + {1'b0, b_i} + {4'd0, rci_i};
    // Bit 4 of the 5-bit difference is the borrow out.
    assign dif = {1'b0, a_i} - {1'b0, b_i} - {4'd0, rci_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q   <= 4'd0;
            rco_q <= 1'b0;
        end else if (enb_i) begin
            case (modo_i)
                MODO_SUMA:  {rco_q, q_q} <= sum;
                MODO_RESTA: {rco_q, q_q} <= dif;
                MODO_CLR:   {rco_q, q_q} <= 5'd0;
                default:    ;
            endcase
        end
    end

    assign q_o   = q_q;
    assign rco_o = rco_q;

endmodule

// File: rtl/secuenciador_sumador16.sv
// Feeds a wide add/sub through the external sumador4 slice, LSB nibble first.
// Latency: START accepted at edge 0 -> Q/COUT/OVF and DONE after edge NIBBLES+1.
// No queueing: START while busy is dropped; back-to-back allowed in the DONE cycle.
import secuenciador_sumador16_pkg::*;

module secuenciador_sumador16 #(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 op_i,
    input  logic [4*NIBBLES-1:0] a_i,
    input  logic [4*NIBBLES-1:0] b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NIBBLES-1:0] q_o,
    output logic                 cout_o,
    output logic                 ovf_o,
    output logic                 s4_enb_o,
    output logic [1:0]           s4_modo_o,
    output logic [3:0]           s4_a_o,
    output logic [3:0]           s4_b_o,
    output logic                 s4_rci_o,
    input  logic [3:0]           s4_q_i,
    input  logic                 s4_rco_i
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] idx_m1;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic          op_q, op_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  q_q, q_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          en_q;
    logic          run;
    logic [3:0]    a_nib, b_nib;

    assign idx_m1 = idx_q - 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    op_d    = op_i;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // The slice result for nibble idx-1 is visible while nibble idx is driven.
                if (idx_q != '0) acc_d[4*idx_m1 +: 4] = s4_q_i;
                if (idx_q == LAST) state_d = ST_FIN;
                else               idx_d   = idx_q + 1'b1;
            end
            ST_FIN: begin
                q_d            = acc_q;
                q_d[W-1 -: 4]  = s4_q_i;
                cout_d         = s4_rco_i;
                ovf_d          = (op_q ? (a_q[W-1] != b_q[W-1]) : (a_q[W-1] == b_q[W-1]))
                                 && (s4_q_i[3] != a_q[W-1]);
                done_d         = 1'b1;
                idx_d          = '0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            acc_q   <= '0;
            q_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            en_q    <= 1'b1;
        end
    end

    secuenciador_sumador16_sel_nibble #(.NIBBLES(NIBBLES), .IW(IW)) u_sel_a (
        .bus_i (a_q),
        .idx_i (idx_q),
        .nib_o (a_nib)
    );

    secuenciador_sumador16_sel_nibble #(.NIBBLES(NIBBLES), .IW(IW)) u_sel_b (
        .bus_i (b_q),
        .idx_i (idx_q),
        .nib_o (b_nib)
    );

    assign run       = (state_q == ST_RUN);
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign q_o       = q_q;
    assign cout_o    = cout_q;
    assign ovf_o     = ovf_q;
    assign s4_enb_o  = en_q;
    assign s4_modo_o = run ? (op_q ? MODO_RESTA : MODO_SUMA) : MODO_HOLD;
    assign s4_a_o    = run ? a_nib : 4'd0;
    assign s4_b_o    = run ? b_nib : 4'd0;
    assign s4_rci_o  = run && (idx_q != '0) && s4_rco_i;

endmodule
